// File: rtl/shifter_pkg.sv
// shifter_pkg: shared mode encodings for the pipelined barrel shifter.
//   mode_t : 2-bit operation select (LSR, LSL, ASR, ROR)
package shifter_pkg;
  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_LSL = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_t;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one registered barrel stage, shifts by DIST when its amount bit is set.
//   clk, rst_n       : clock, async active-low reset
//   flush, advance   : sync clear of valid; pipeline enable
//   in_*             : valid, data, amount, mode, fill bit from the previous stage
//   out_*            : the same sideband, registered, plus the shifted data
import shifter_pkg::*;
module shift_stage #(
  parameter int WIDTH = 32,
  parameter int DIST = 1,
  localparam int SHW = $clog2(WIDTH),
  localparam int K = $clog2(DIST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  mode_t            in_mode,
  input  logic             in_fill,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output mode_t            out_mode,
  output logic             out_fill
);
  logic [WIDTH-1:0] lsr, lsl, ror, nxt;
  // LSR and ASR share one path; the fill bit is 0 unless ASR of a negative word.
  assign lsr = {{DIST{in_fill}}, in_data[WIDTH-1:DIST]};
  assign lsl = {in_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
  assign ror = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
  always_comb
    nxt = !in_amt[K] ? in_data : in_mode == MODE_LSL ? lsl : in_mode == MODE_ROR ? ror : lsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_amt <= '0;
      out_mode <= MODE_LSR;
      out_fill <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_data <= nxt;
      out_amt <= in_amt;
      out_mode <= in_mode;
      out_fill <= in_fill;
    end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(WIDTH)-stage registered shifter (LSR/LSL/ASR/ROR) with valid/ready.
//   clk, rst_n                 : clock, async active-low reset
//   flush                      : sync clear of all in-flight words
//   in_valid/in_ready          : input handshake; in_data, in_amt, in_mode operand
//   out_valid/out_ready        : output handshake; out_data result
//   busy                       : any stage holds a valid word
import shifter_pkg::*;
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  logic             advance;
  logic             v [0:SHW];
  logic [WIDTH-1:0] d [0:SHW];
  logic [SHW-1:0]   a [0:SHW];
  mode_t            m [0:SHW];
  logic             f [0:SHW];
  // The whole pipe moves in lockstep, so bubbles are preserved.
  assign advance = !out_valid || out_ready;
  assign in_ready = advance && !flush;
  assign v[0] = in_valid && in_ready;
  assign d[0] = in_data;
  assign a[0] = in_amt;
  assign m[0] = mode_t'(in_mode);
  assign f[0] = m[0] == MODE_ASR && in_data[WIDTH-1];
  for (genvar i = 0; i < SHW; i++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .DIST(1 << i)) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .advance(advance),
      .in_valid(v[i]),
      .in_data(d[i]),
      .in_amt(a[i]),
      .in_mode(m[i]),
      .in_fill(f[i]),
      .out_valid(v[i+1]),
      .out_data(d[i+1]),
      .out_amt(a[i+1]),
      .out_mode(m[i+1]),
      .out_fill(f[i+1])
    );
  end
  assign out_valid = v[SHW];
  assign out_data = d[SHW];
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= SHW; k++) busy = busy | v[k];
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; a power of two, 8 to 128.
REQ-002 SHALL have derived localparam SHW = log2(WIDTH), default 5, shift-amount width and stage count.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline clear.
REQ-006 SHALL have port in_valid  input  1  input word offered.
REQ-007 SHALL have port in_ready  output  1  input word accepted this cycle when high with in_valid.
REQ-008 SHALL have port in_data  input  WIDTH  operand.
REQ-009 SHALL have port in_amt  input  SHW  shift amount, 0..WIDTH-1.
REQ-010 SHALL have port in_mode  input  2  operation: 00 LSR, 01 LSL, 10 ASR, 11 ROR.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port out_data  output  WIDTH  result.
REQ-014 SHALL have port busy  output  1  high when any stage holds a valid word.

Function
REQ-015 SHALL implement SHW cascaded stages; stage k shifts by 2^k when amt bit k is set, else passes through.
REQ-016 SHALL register every stage output, so latency is exactly SHW cycles from acceptance to out_valid with out_ready held high.
REQ-017 SHALL carry valid, mode, remaining amount bits and fill bit with the data through each stage.
REQ-018 SHALL fill with 0 for LSR/LSL, with in_data[WIDTH-1] (captured at acceptance) for ASR, and wrap vacated bits for ROR.
REQ-019 SHALL pass the word unchanged when in_amt = 0, in every mode.
REQ-020 SHALL advance all stages together on advance = !out_valid || out_ready; no stage updates when advance is low.
REQ-021 SHALL drive in_ready = advance && !flush, combinationally.
REQ-022 SHALL preserve bubbles: an empty stage stays empty as it moves, with no bubble collapsing.
REQ-023 SHALL accept one word per cycle at full throughput when out_ready is held high.
REQ-024 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-025 On flush, SHALL clear all stage valid bits and out_valid at the next edge.
REQ-026 On flush, SHALL drop any simultaneously offered input; flush wins over in_valid and out_ready.
REQ-027 SHALL compute results identical to the unpipelined reference function for all WIDTH, amount and mode combinations.

Reset
REQ-028 While rst_n is low, SHALL force all stage valid bits, out_valid and busy to 0, and out_data and stage data to 0, asynchronously.
REQ-029 SHALL drive in_ready high in the first cycle after rst_n deasserts if flush is low.
REQ-030 SHALL discard, not complete, all in-flight words when reset asserts mid-operation.

Structure
REQ-031 SHALL take the mode encodings (MODE_LSR, MODE_LSL, MODE_ASR, MODE_ROR) and the 2-bit mode type from shared package shifter_pkg.
REQ-032 SHALL instantiate one sub-module, shift_stage (parameters WIDTH, DIST), per stage: a registered single-distance shift with valid/mode/fill sideband.

Verification
REQ-033 The bench SHALL check, at WIDTH=32: LSR 0x80000000 amt 31 -> 0x00000001; LSL 0x00000001 amt 31 -> 0x80000000; each result exactly 5 cycles after acceptance.
REQ-034 The bench SHALL check: ASR 0x80000000 amt 4 -> 0xF8000000; ASR 0x40000000 amt 4 -> 0x04000000; ROR 0x00000001 amt 1 -> 0x80000000; any mode, amt 0 -> input unchanged.
REQ-035 The bench SHALL check back-to-back streaming of 8 words with out_ready high: 8 results on 8 consecutive cycles, in order.
REQ-036 The bench SHALL check backpressure: 3 words issued, then out_ready low for 5 cycles. Required: in_ready low while out_valid && !out_ready, out_data stable, no loss, order preserved after release.
REQ-037 The bench SHALL check flush with 3 words in flight plus in_valid the same cycle. Required: the next cycle shows out_valid=0, busy=0, and no result ever emerges.
REQ-038 The bench SHALL check rst_n pulsed low mid-stream. Required: outputs go to 0 immediately; in_ready=1 after release; the next accepted word yields a correct result.
